// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: ce in, undelayed counters plus delayed sync/blank/strobe out.
// Combinational only; ce is the sole flow-control signal (no backpressure).
interface video_timing_gen_if #(
  parameter int CW = 11
);
  logic          ce;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          hblank;
  logic          vblank;
  logic          display_enable;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  ce,
    output hcount, vcount, hsync, vsync, hblank, vblank,
           display_enable, line_start, frame_start
  );

  modport slave (
    output ce,
    input  hcount, vcount, hsync, vsync, hblank, vblank,
           display_enable, line_start, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator; timing outputs lag the counters by DELAY+1 ce edges.
// No backpressure: ce gates every register, and with ce low all state and outputs hold.
module video_timing_gen #(
  parameter int CW        = 11,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int DELAY     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  video_timing_gen_if.master   tif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
    logic de;
    logic line_start;
    logic frame_start;
  } tvec_t;

  localparam tvec_t INACTIVE = tvec_t'({~HSYNC_POL, ~VSYNC_POL, 5'b11000});

  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  tvec_t         dec;
  tvec_t         pipe [DELAY+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (tif.ce) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + CW'(1);
      end else begin
        hcount <= hcount + CW'(1);
      end
    end
  end

  // vsync decodes from vcount alone, so it can only move where vcount does: at hcount=0.
  always_comb begin
    dec             = INACTIVE;
    dec.hblank      = (hcount >= H_ACT);
    dec.vblank      = (vcount >= V_ACT);
    dec.hsync       = ((hcount >= HS_START) && (hcount < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    dec.vsync       = ((vcount >= VS_START) && (vcount < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    dec.de          = ~dec.hblank & ~dec.vblank;
    dec.line_start  = (hcount == '0);
    dec.frame_start = (hcount == '0) && (vcount == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= DELAY; i++) pipe[i] <= INACTIVE;
    end else if (tif.ce) begin
      pipe[0] <= dec;
      for (int i = 1; i <= DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tif.hcount         = hcount;
  assign tif.vcount         = vcount;
  assign tif.hsync          = pipe[DELAY].hsync;
  assign tif.vsync          = pipe[DELAY].vsync;
  assign tif.hblank         = pipe[DELAY].hblank;
  assign tif.vblank         = pipe[DELAY].vblank;
  assign tif.display_enable = pipe[DELAY].de;
  assign tif.line_start     = pipe[DELAY].line_start;
  assign tif.frame_start    = pipe[DELAY].frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Two small raster modes driven by shared random ce/reset, checked each cycle against
// an edge-count model: outputs after k ce edges are the decode of raster position k-LAT.
module tb_video_timing_gen;

  localparam int CW = 6;

  // Mode A: 4/1/1/1 x 3/1/1/1, DELAY=1, active-low syncs
  localparam int AHA = 4,  AHF = 1, AHS = 1, AHB = 1;
  localparam int AVA = 3,  AVF = 1, AVS = 1, AVB = 1;
  localparam int ADL = 1;
  localparam bit AHP = 1'b0, AVP = 1'b0;
  // Mode B: 10/2/3/2 x 5/1/2/1, DELAY=3, active-high syncs
  localparam int BHA = 10, BHF = 2, BHS = 3, BHB = 2;
  localparam int BVA = 5,  BVF = 1, BVS = 2, BVB = 1;
  localparam int BDL = 3;
  localparam bit BHP = 1'b1, BVP = 1'b1;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  int   k;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CW(CW)) ifa ();
  video_timing_gen_if #(.CW(CW)) ifb ();
  assign ifa.ce = ce;
  assign ifb.ce = ce;

  video_timing_gen #(
    .CW(CW), .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .HSYNC_POL(AHP), .VSYNC_POL(AVP), .DELAY(ADL)
  ) dut_a (.clk(clk), .reset(reset), .tif(ifa.master));

  video_timing_gen #(
    .CW(CW), .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .HSYNC_POL(BHP), .VSYNC_POL(BVP), .DELAY(BDL)
  ) dut_b (.clk(clk), .reset(reset), .tif(ifb.master));

  // Number of ce-qualified edges since the last reset.
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else if (ce) k <= k + 1;
  end

  // {hsync, vsync, hblank, vblank, display_enable, line_start, frame_start}
  function automatic logic [6:0] exp_vec(input int kk, input int ha, input int hf, input int hs,
                                         input int hb, input int va, input int vf, input int vs,
                                         input int vb, input int lat, input bit hp, input bit vp);
    int ht, vt, idx, h, v;
    bit hbl, vbl, hact, vact;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (kk < lat) return {~hp, ~vp, 1'b1, 1'b1, 3'b000};
    idx  = kk - lat;
    h    = idx % ht;
    v    = (idx / ht) % vt;
    hbl  = (h >= ha);
    vbl  = (v >= va);
    hact = (h >= ha + hf) && (h < ha + hf + hs);
    vact = (v >= va + vf) && (v < va + vf + vs);
    return {hact ? hp : ~hp, vact ? vp : ~vp, hbl, vbl, ~hbl & ~vbl, h == 0, (h == 0) && (v == 0)};
  endfunction

  function automatic logic [6:0] vec_a();
    return {ifa.hsync, ifa.vsync, ifa.hblank, ifa.vblank, ifa.display_enable,
            ifa.line_start, ifa.frame_start};
  endfunction

  function automatic logic [6:0] vec_b();
    return {ifb.hsync, ifb.vsync, ifb.hblank, ifb.vblank, ifb.display_enable,
            ifb.line_start, ifb.frame_start};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s at t=%0t k=%0d: got %0h, want %0h", name, $time, k, act, exp);
    else n_pass++;
  endtask

  task automatic compare_all();
    int hta, vta, htb, vtb;
    hta = AHA + AHF + AHS + AHB;  vta = AVA + AVF + AVS + AVB;
    htb = BHA + BHF + BHS + BHB;  vtb = BVA + BVF + BVS + BVB;
    chk("a_hcount", 32'(ifa.hcount), 32'(k % hta));
    chk("a_vcount", 32'(ifa.vcount), 32'((k / hta) % vta));
    chk("a_vec", 32'(vec_a()), 32'(exp_vec(k, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, ADL + 1, AHP, AVP)));
    chk("b_hcount", 32'(ifb.hcount), 32'(k % htb));
    chk("b_vcount", 32'(ifb.vcount), 32'((k / htb) % vtb));
    chk("b_vec", 32'(vec_b()), 32'(exp_vec(k, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, BDL + 1, BHP, BVP)));
  endtask

  task automatic do_reset();
    int n;
    ce = 1'b1;
    n  = 0;
    while (ifb.hcount != CW'(8) && n < 100) begin
      @(posedge clk);
      #4;
      compare_all();
      n++;
    end
    chk("reset_wait_hcount8", 32'(n < 100), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_a_vec", 32'(vec_a()), 32'(7'b1111000));
    chk("async_rst_b_vec", 32'(vec_b()), 32'(7'b0011000));
    chk("async_rst_hcount", 32'(ifb.hcount), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #4;
      compare_all();
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #3 compare_all();
  endtask

  initial begin
    int fs_a, ls_a, fs_b, ls_b;
    reset = 1'b1;
    ce    = 1'b0;
    #2;
    chk("reset_a_vec", 32'(vec_a()), 32'(7'b1111000));
    chk("reset_b_vec", 32'(vec_b()), 32'(7'b0011000));
    chk("reset_a_hcount", 32'(ifa.hcount), 32'd0);
    @(posedge clk);
    #1 ce = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    // Free-running ce: edge e lands on posedge number e after release
    fs_a = 0; ls_a = 0; fs_b = 0; ls_b = 0;
    for (int e = 1; e <= 160; e++) begin
      @(posedge clk);
      #3;
      compare_all();
      fs_a += int'(ifa.frame_start);
      ls_a += int'(ifa.line_start);
      fs_b += int'(ifb.frame_start);
      ls_b += int'(ifb.line_start);
      case (e)
        1:  begin
              chk("a_e1_vec", 32'(vec_a()), 32'(7'b1111000));
              chk("a_e1_hcount", 32'(ifa.hcount), 32'd1);
            end
        2:  chk("a_e2_first_frame", 32'(vec_a()), 32'(7'b1100111));
        3:  chk("b_e3_inactive", 32'(vec_b()), 32'(7'b0011000));
        4:  chk("b_e4_first_frame", 32'(vec_b()), 32'(7'b0000111));
        7:  begin
              chk("a_e7_hwrap", 32'({ifa.vcount, ifa.hcount}), 32'({6'd1, 6'd0}));
              chk("a_e7_hsync", 32'(vec_a()), 32'(7'b0110000));
            end
        9:  chk("a_e9_line1", 32'(vec_a()), 32'(7'b1100110));
        15: chk("b_e15_pre_hsync", 32'(vec_b()), 32'(7'b0010000));
        16: chk("b_e16_hsync_on", 32'(vec_b()), 32'(7'b1010000));
        19: chk("b_e19_hsync_off", 32'(vec_b()), 32'(7'b0010000));
        30: chk("a_e30_vsync", 32'(vec_a()), 32'(7'b1001010));
        41: chk("a_e41_both_wrap", 32'({ifa.vcount, ifa.hcount}), 32'({6'd5, 6'd6}));
        42: chk("a_e42_zero", 32'({ifa.vcount, ifa.hcount}), 32'd0);
        44: chk("a_e44_frame", 32'(vec_a()), 32'(7'b1100111));
        default: ;
      endcase
    end
    chk("a_frame_count", 32'(fs_a), 32'd4);
    chk("a_line_count", 32'(ls_a), 32'd23);
    chk("b_frame_count", 32'(fs_b), 32'd2);
    chk("b_line_count", 32'(ls_b), 32'd10);

    // Throttled then random ce, with asynchronous resets mid-line
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc % 1500 == 750) do_reset();
      @(posedge clk);
      #1;
      if (cyc < 2000) ce = cyc[0];
      else ce = ($urandom_range(0, 3) != 0);
      #3 compare_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the HDMI/VGA video path. Drives `hsync`, `vsync`, `hblank`, `vblank` and `display_enable` for any mode set by parameters, and exposes pixel coordinates for the example pixel logic. It sits between the pixel clock domain (`clk25m`-class clock) and the HDMI encoder input. A programmable delay line keeps the sync and blank signals aligned with pixel pipelines of known latency, such as ROM or character lookups.

## Interface
- `CW`, 11: width of the `hcount`/`vcount` counters. Requires `H_TOTAL` ≤ 2^CW and `V_TOTAL` ≤ 2^CW.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `HSYNC_POL`, 0: active level of `hsync` (0 = active-low).
- `VSYNC_POL`, 0: active level of `vsync` (0 = active-low).
- `DELAY`, 1: extra pipeline stages applied to the timing outputs. Range 0..8.
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. LAT = DELAY+1.
- Every porch and sync width must be ≥1.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  pixel enable. Counters and the delay line advance only when `ce`=1.
- `hcount`  out  CW  current horizontal position (undelayed).
- `vcount`  out  CW  current vertical position (undelayed).
- `hsync`  out  1  horizontal sync, polarity set by `HSYNC_POL`, delayed by LAT.
- `vsync`  out  1  vertical sync, polarity set by `VSYNC_POL`, delayed by LAT.
- `hblank`  out  1  high outside the active columns, delayed by LAT.
- `vblank`  out  1  high outside the active lines, delayed by LAT.
- `display_enable`  out  1  equals ~hblank & ~vblank, delayed by LAT.
- `line_start`  out  1  single-`ce` pulse for the delayed point hcount=0.
- `frame_start`  out  1  single-`ce` pulse for the delayed point hcount=0, vcount=0.

## Operation
- `hcount` counts 0..H_TOTAL-1 and then wraps to 0.
- On an `hcount` wrap, `vcount` increments. It wraps 0..V_TOTAL-1.
- When both counters sit at their maximum on the same `ce`, both return to 0 together.
- Decode from the current counters:
  - hblank = hcount ≥ H_ACTIVE.
  - hsync is active for H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC.
  - vblank and vsync use the same rules on `vcount` with the V_* parameters.
  - `vsync` changes only at the hcount=0 boundary.
- The decoded vector {hs, vs, hb, vb, de, ls, fs} is captured into a register on `ce`. It then passes through `DELAY` further `ce`-gated stages. The last stage drives the outputs.
- `hcount` and `vcount` are not delayed. Pixel logic with latency LAT, fed from the counters, lines up exactly with the outputs.
- `ce`=0: all state holds, including counters and every delay stage. Outputs stay static.
- Reset (asynchronous, any time):
  - Counters go to 0.
  - Every delay stage loads the inactive vector: hsync=~HSYNC_POL, vsync=~VSYNC_POL, hblank=1, vblank=1, display_enable=0, line_start=0, frame_start=0.
  - Output values take effect immediately, with no clock edge needed.
- After reset release, the first LAT `ce` cycles present the inactive vector.
- The first `frame_start` appears on the LAT-th `ce` edge after release, because counter (0,0) is the first decoded state.

## Timing
- Latency from counter value to timing outputs is exactly LAT `ce`-qualified clock edges.
- Line period is H_TOTAL `ce` cycles. Frame period is H_TOTAL×V_TOTAL `ce` cycles. With defaults that is 800 and 420 000.
- `line_start` and `frame_start` are high for exactly one clock, namely the clock after the qualifying `ce` edge. If `ce` stays low afterwards, the pulse is held until the next `ce` edge. Consumers must qualify both pulses with `ce`.
- All outputs are registered, so they are glitch-free and safe for the TMDS encoder.

## Test plan
- **Reset behaviour.** Assert `reset` mid-line at hcount=300 with clk running → all outputs go to the inactive vector (hsync=1, vsync=1, hblank=1, vblank=1, display_enable=0) without a clock edge. After release, `hcount` restarts at 0.
- **Horizontal timing, defaults, `ce`=1.** `hsync` low for exactly 96 clocks, falling LAT=2 clocks after hcount=656. `hblank` rises 2 clocks after hcount=640. `line_start` repeats every 800 clocks.
- **Vertical timing.** `vsync` low for lines 490–491 (1600 clocks). `vblank` covers lines 480–524. `frame_start` occurs once per 420 000 clocks. `display_enable` count per frame = 307 200.
- **`ce` throttling.** `ce` toggles 1/0 → line period is 1600 clocks and `hsync` width is 192 clocks. Outputs never change on a clock where `ce`=0.
- **Delay and polarity.** DELAY=3, HSYNC_POL=1, VSYNC_POL=1 → `hsync` high (active) starting 4 `ce` cycles after hcount=656. `display_enable` rises 4 `ce` cycles after the (0,0) counter state.
- **Small mode, wrap boundaries.** H params 4/1/1/1 and V params 3/1/1/1 (H_TOTAL=7, V_TOTAL=6) → hcount sequence 0..6,0 and vcount 0..5,0. Both counters wrap to (0,0) on the same edge, and `frame_start` occurs every 42 cycles.
